// File: rtl/prog_loader.sv
// Instruction-memory loader: streams a program in, then feeds it to the processor.
// Optional macro PROG_LOADER_CHECKSUM_EN adds a running 16-bit sum of loaded words.
module prog_loader #(
    parameter int DEPTH = 32
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        LoadStart,
    input  logic        LoadValid,
    input  logic [15:0] LoadData,
    input  logic        LoadLast,
    output logic        LoadReady,
    input  logic        FetchNext,
    output logic [4:0]  Addr,
    output logic [15:0] Instr,
    output logic        InstrValid,
    output logic        Running,
    output logic [5:0]  ProgLen,
    output logic        Wrap,
    output logic        Overflow,
    output logic [15:0] Checksum
);

    localparam logic [5:0] LAST_LEN = 6'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  wptr_q, wptr_d;
    logic [5:0]  prog_len_q, prog_len_d;
    logic        overflow_q, overflow_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        wrap_q, wrap_d;
    logic        accept;
    logic        last_beat;
    logic [15:0] mem [DEPTH];

    // A beat coinciding with LoadStart is dropped: the restart wins.
    assign accept    = (state_q == LOAD) && LoadValid && !LoadStart;
    assign last_beat = accept && (LoadLast || prog_len_q == LAST_LEN);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q       <= IDLE;
            wptr_q        <= '0;
            prog_len_q    <= '0;
            overflow_q    <= 1'b0;
            addr_q        <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            prog_len_q    <= prog_len_d;
            overflow_q    <= overflow_d;
            addr_q        <= addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            wrap_q        <= wrap_d;
        end
    end

    // Memory is deliberately left uninitialised by reset.
    always_ff @(posedge Clock) begin
        if (Reset && accept) begin
            mem[wptr_q] <= LoadData;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (LoadStart) state_d = LOAD;
            LOAD: begin
                if (LoadStart)      state_d = LOAD;
                else if (last_beat) state_d = RUN;
            end
            RUN:  if (LoadStart) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wptr_d        = wptr_q;
        prog_len_d    = prog_len_q;
        overflow_d    = overflow_q;
        addr_d        = addr_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        wrap_d        = 1'b0;
        if (LoadStart) begin
            wptr_d     = '0;
            prog_len_d = '0;
            overflow_d = 1'b0;
            addr_d     = '0;
            instr_d    = '0;
        end else if (accept) begin
            wptr_d     = wptr_q + 5'd1;
            prog_len_d = prog_len_q + 6'd1;
            overflow_d = !LoadLast && (prog_len_q == LAST_LEN);
            addr_d     = '0;
        end else if (state_q == RUN) begin
            if (FetchNext) begin
                if ({1'b0, addr_q} + 6'd1 == prog_len_q) begin
                    addr_d = '0;
                    wrap_d = 1'b1;
                end else begin
                    addr_d = addr_q + 5'd1;
                end
            end else begin
                instr_d       = mem[addr_q];
                instr_valid_d = 1'b1;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (LoadStart)   checksum_d = '0;
        else if (accept) checksum_d = checksum_q + LoadData;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) checksum_q <= '0;
        else        checksum_q <= checksum_d;
    end

    assign Checksum = checksum_q;
`else
    assign Checksum = 16'h0000;
`endif

    always_comb begin
        LoadReady  = (state_q == LOAD);
        Running    = (state_q == RUN);
        Addr       = addr_q;
        Instr      = instr_q;
        InstrValid = instr_valid_q;
        ProgLen    = prog_len_q;
        Wrap       = wrap_q;
        Overflow   = overflow_q;
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
// Expected checksums follow PROG_LOADER_CHECKSUM_EN when it is defined.
module tb_prog_loader;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        LoadStart = 1'b0;
    logic        LoadValid = 1'b0;
    logic [15:0] LoadData = '0;
    logic        LoadLast = 1'b0;
    logic        LoadReady;
    logic        FetchNext = 1'b0;
    logic [4:0]  Addr;
    logic [15:0] Instr;
    logic        InstrValid;
    logic        Running;
    logic [5:0]  ProgLen;
    logic        Wrap;
    logic        Overflow;
    logic [15:0] Checksum;

    int checks = 0;
    int failures = 0;

    prog_loader dut (
        .Clock(Clock), .Reset(Reset),
        .LoadStart(LoadStart), .LoadValid(LoadValid),
        .LoadData(LoadData), .LoadLast(LoadLast),
        .LoadReady(LoadReady), .FetchNext(FetchNext),
        .Addr(Addr), .Instr(Instr), .InstrValid(InstrValid),
        .Running(Running), .ProgLen(ProgLen), .Wrap(Wrap),
        .Overflow(Overflow), .Checksum(Checksum)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [15:0] csum(input logic [15:0] s);
`ifdef PROG_LOADER_CHECKSUM_EN
        return s;
`else
        return 16'h0000 & s;
`endif
    endfunction

    task automatic beat(input logic [15:0] d, input logic last);
        LoadValid = 1'b1;
        LoadData  = d;
        LoadLast  = last;
        tick();
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
    endtask

    task automatic fetch();
        FetchNext = 1'b1;
        tick();
        FetchNext = 1'b0;
    endtask

    initial begin
        // reset state
        Reset = 1'b0;
        LoadValid = 1'b1;
        tick();
        tick();
        LoadValid = 1'b0;
        check("rst_running", Running, 0);
        check("rst_ready", LoadReady, 0);
        check("rst_len", ProgLen, 0);
        check("rst_addr", Addr, 0);
        check("rst_instr", Instr, 0);
        check("rst_ivalid", InstrValid, 0);
        check("rst_wrap", Wrap, 0);
        check("rst_ovf", Overflow, 0);
        check("rst_csum", Checksum, 0);
        Reset = 1'b1;

        // FetchNext ignored in IDLE
        fetch();
        check("idle_fetch_addr", Addr, 0);
        check("idle_running", Running, 0);

        // three-word load
        LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        check("load_ready", LoadReady, 1);
        check("load_ivalid", InstrValid, 0);
        beat(16'h1C0A, 1'b0);
        beat(16'h0008, 1'b0);
        check("load_len2", ProgLen, 2);
        beat(16'h0003, 1'b1);
        check("l3_running", Running, 1);
        check("l3_len", ProgLen, 3);
        check("l3_addr", Addr, 0);
        check("l3_ivalid0", InstrValid, 0);
        check("l3_ready", LoadReady, 0);
        check("l3_csum", Checksum, csum(16'h1C15));
        tick();
        check("l3_ivalid1", InstrValid, 1);
        check("l3_instr", Instr, 16'h1C0A);

        // fetch walk with wrap
        fetch();
        check("f1_addr", Addr, 1);
        check("f1_ivalid", InstrValid, 0);
        check("f1_wrap", Wrap, 0);
        tick();
        check("f1_instr", Instr, 16'h0008);
        check("f1_ivalid1", InstrValid, 1);
        fetch();
        check("f2_addr", Addr, 2);
        tick();
        check("f2_instr", Instr, 16'h0003);
        fetch();
        check("f3_addr", Addr, 0);
        check("f3_wrap", Wrap, 1);
        tick();
        check("f3_wrap_off", Wrap, 0);
        check("f3_instr", Instr, 16'h1C0A);
        check("f3_ivalid", InstrValid, 1);
        fetch();
        fetch();
        check("f5_addr", Addr, 2);

        // LoadStart aborts the run and beats FetchNext
        LoadStart = 1'b1;
        FetchNext = 1'b1;
        tick();
        LoadStart = 1'b0;
        FetchNext = 1'b0;
        check("abort_running", Running, 0);
        check("abort_ready", LoadReady, 1);
        check("abort_addr", Addr, 0);
        check("abort_ivalid", InstrValid, 0);
        check("abort_instr", Instr, 0);
        check("abort_len", ProgLen, 0);

        // toggling LoadValid, Last on 2nd valid
        beat(16'hAAAA, 1'b0);
        tick();
        check("tog_gap_len", ProgLen, 1);
        beat(16'hBBBB, 1'b1);
        check("tog_len", ProgLen, 2);
        check("tog_running", Running, 1);
        tick();
        check("tog_i0", Instr, 16'hAAAA);
        fetch();
        tick();
        check("tog_i1", Instr, 16'hBBBB);
        fetch();
        check("tog_wrap", Wrap, 1);
        check("tog_wrap_addr", Addr, 0);

        // checksum wraps modulo 2^16
        LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        check("cs_clear", Checksum, 0);
        beat(16'hFFFF, 1'b0);
        beat(16'h0002, 1'b1);
        check("cs_val", Checksum, csum(16'h0001));
        check("cs_len", ProgLen, 2);

        // overflow: 33 beats with no Last
        LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        for (int i = 0; i < 31; i++) beat(16'h0100 + 16'(i), 1'b0);
        check("ov31_ready", LoadReady, 1);
        check("ov31_flag", Overflow, 0);
        beat(16'h0100 + 16'd31, 1'b0);
        check("ov_flag", Overflow, 1);
        check("ov_len", ProgLen, 32);
        check("ov_running", Running, 1);
        check("ov_ready33", LoadReady, 0);
        check("ov_csum", Checksum, csum(16'h21F0));
        beat(16'hDEAD, 1'b0);
        check("ov_len33", ProgLen, 32);
        check("ov_i0", Instr, 16'h0100);
        check("ov_iv", InstrValid, 1);
        check("ov_csum33", Checksum, csum(16'h21F0));

        // reset mid-load, then single-word reload
        LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        beat(16'h1111, 1'b0);
        beat(16'h2222, 1'b0);
        Reset = 1'b0;
        LoadStart = 1'b1;
        beat(16'h3333, 1'b1);
        LoadStart = 1'b0;
        check("mrst_running", Running, 0);
        check("mrst_ready", LoadReady, 0);
        check("mrst_len", ProgLen, 0);
        check("mrst_csum", Checksum, 0);
        Reset = 1'b1;
        tick();
        check("mrst_idle_ready", LoadReady, 0);
        LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        beat(16'h5A5A, 1'b1);
        check("one_len", ProgLen, 1);
        tick();
        check("one_instr", Instr, 16'h5A5A);
        fetch();
        check("one_addr", Addr, 0);
        check("one_wrap", Wrap, 1);
        tick();
        check("one_wrap_off", Wrap, 0);
        check("one_instr2", Instr, 16'h5A5A);
        fetch();
        check("one_wrap2", Wrap, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 32, instruction memory depth in 16-bit words; address width is 5 bits.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  reset, synchronous, active-low.
REQ-004 LoadStart  input  1  one-cycle pulse; begins a new program load.
REQ-005 LoadValid  input  1  load beat valid.
REQ-006 LoadData  input  16  instruction word for the current beat.
REQ-007 LoadLast  input  1  marks the final beat; qualified by LoadValid.
REQ-008 LoadReady  output  1  loader accepts a beat this cycle.
REQ-009 FetchNext  input  1  processor instruction-complete pulse (the processor's Done); advances fetch.
REQ-010 Addr  output  5  current fetch address.
REQ-011 Instr  output  16  instruction word presented on the processor's DIN.
REQ-012 InstrValid  output  1  Instr holds mem[Addr].
REQ-013 Running  output  1  high in RUN.
REQ-014 ProgLen  output  6  number of words loaded, 0..32.
REQ-015 Wrap  output  1  one-cycle pulse when Addr wraps to 0.
REQ-016 Overflow  output  1  sticky; load truncated at DEPTH words.
REQ-017 Checksum  output  16  modulo-2^16 sum of the loaded words.

Function
REQ-018 States SHALL be IDLE, LOAD, and RUN.
REQ-019 IDLE->LOAD on LoadStart; RUN->LOAD on LoadStart (aborts the run); LOAD->RUN on an accepted beat with LoadLast, or on the accepted DEPTH-th beat.
REQ-020 On entering LOAD: write pointer = 0, ProgLen = 0, Overflow = 0, Checksum = 0.
REQ-021 LoadReady SHALL be high only in LOAD; a beat is accepted when LoadValid and LoadReady are both high in the same cycle.
REQ-022 Each accepted beat writes mem[wptr] = LoadData, then increments wptr and ProgLen; LoadValid with LoadReady low is ignored.
REQ-023 If the DEPTH-th accepted beat has LoadLast = 0, Overflow SHALL set, and any further beats are not accepted.
REQ-024 LoadStart inside LOAD restarts the load: wptr = 0 and ProgLen = 0.
REQ-025 On entering RUN: Addr = 0; Instr = mem[0] with InstrValid high one cycle after entry (registered read, latency 1).
REQ-026 In RUN, FetchNext increments Addr; when Addr = ProgLen-1, Addr wraps to 0 and Wrap pulses in the same cycle Addr becomes 0.
REQ-027 After each Addr change, InstrValid is low for 1 cycle, then Instr = mem[Addr] with InstrValid high.
REQ-028 FetchNext is ignored outside RUN, and ignored on the same cycle as LoadStart (LoadStart wins).
REQ-029 A LOAD ending with ProgLen = 0 is impossible, because the exit condition requires an accepted beat; ProgLen = 1 holds Addr at 0 and pulses Wrap on every FetchNext.
REQ-030 Instr = 0 and InstrValid = 0 in IDLE and LOAD.

Reset
REQ-031 Reset low at a Clock edge: state IDLE, Addr = 0, Instr = 0, InstrValid = 0, Running = 0, LoadReady = 0, ProgLen = 0, Wrap = 0, Overflow = 0, Checksum = 0, wptr = 0.
REQ-032 Memory contents are not cleared by reset.
REQ-033 Reset mid-load or mid-run takes priority over all other inputs; the beat on the reset cycle is dropped.

Configuration
REQ-034 Macro PROG_LOADER_CHECKSUM_EN defined: each accepted beat adds LoadData to Checksum, modulo 2^16.
REQ-035 PROG_LOADER_CHECKSUM_EN undefined: Checksum is tied to 0 and no adder is synthesized.

Verification
REQ-036 Reset, LoadStart, beats 0x1C0A, 0x0008, 0x0003 (Last on 3rd) -> ProgLen = 3, RUN, Addr = 0, Instr = 0x1C0A one cycle later.
REQ-037 In RUN with ProgLen = 3, 3 FetchNext pulses -> Addr goes 1, 2, 0; Wrap pulses once; Instr = 0x1C0A again.
REQ-038 33 beats without LoadLast -> 32 accepted, Overflow = 1, RUN entered, LoadReady low on beat 33.
REQ-039 LoadValid toggling 1/0/1 with Last on 2nd valid -> exactly 2 words written; LoadStart during RUN at Addr = 2 -> LOAD, Addr = 0, InstrValid = 0.
REQ-040 Reset low during LOAD after 2 beats -> IDLE, ProgLen = 0; a reload of 1 word then reads back the new value.
REQ-041 With checksum enabled, beats 0xFFFF and 0x0002 -> Checksum = 0x0001; with it disabled -> Checksum = 0.
